ar_freeze_ctrl: RTL and testbench



---
 rtl/ar_freeze_ctrl_if.sv | 23 ++
 rtl/ar_freeze_ctrl.sv | 116 +++++++++++
 tb/tb_ar_freeze_ctrl.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ar_freeze_ctrl_if.sv
// Keyboard/OSD request bundle into ar_freeze_ctrl and its freeze/status outputs.
// keystroke is a one-cycle valid qualifying keycode; there is no ready, the controller accepts every strobe.
interface ar_freeze_ctrl_if;
    logic [7:0] keycode;
    logic       keystroke;
    logic       osd_freeze;
    logic       enable;
    logic       freeze;
    logic       kbd_block;
    logic       ctrl_down;
    logic       busy;
    logic [1:0] state;

    modport master (
        output keycode, keystroke, osd_freeze, enable,
        input  freeze, kbd_block, ctrl_down, busy, state
    );

    modport slave (
        input  keycode, keystroke, osd_freeze, enable,
        output freeze, kbd_block, ctrl_down, busy, state
    );
endinterface

// File: rtl/ar_freeze_ctrl.sv
// Ctrl+Break / OSD freeze request generator for the Action Replay cartridge:
// fixed-length freeze pulse, hold-until-release, and a re-arm gap.
module ar_freeze_ctrl #(
    parameter logic [7:0] FREEZE_CODE  = 8'h5D,
    parameter logic [7:0] CTRL_CODE    = 8'h63,
    parameter logic [7:0] RSTWARN_CODE = 8'h78,
    parameter int         PULSE_LEN    = 16,
    parameter int         GAP_LEN      = 1024
) (
    input logic             clk,
    input logic             _reset,
    ar_freeze_ctrl_if.slave bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_PULSE, ST_HOLD, ST_GAP} state_t;

    localparam logic [15:0] PULSE_RLD = 16'(PULSE_LEN - 1);
    localparam logic [15:0] GAP_RLD   = 16'(GAP_LEN - 1);

    state_t      state_q;
    logic [15:0] cnt_q;
    logic        freeze_q;
    logic        kbd_block_q;
    logic        ctrl_down_q, ctrl_down_d;
    logic        brk_down_q, brk_down_d;
    logic        osd_del_q;

    logic brk_match, brk_press, brk_release, rstwarn, osd_rise, trigger;

    assign brk_match   = bus.keystroke && (bus.keycode[6:0] == FREEZE_CODE[6:0]);
    assign brk_press   = brk_match && !bus.keycode[7];
    assign brk_release = brk_match && bus.keycode[7];
    assign rstwarn     = bus.keystroke && (bus.keycode == RSTWARN_CODE);
    assign osd_rise    = bus.osd_freeze && !osd_del_q;
    // Uses the Ctrl state from before this strobe; one strobe carries one key.
    assign trigger     = bus.enable &&
                         ((bus.keystroke && (bus.keycode == FREEZE_CODE) && ctrl_down_q) || osd_rise);

    always_comb begin
        ctrl_down_d = ctrl_down_q;
        brk_down_d  = brk_down_q;
        if (bus.keystroke && (bus.keycode == CTRL_CODE))
            ctrl_down_d = 1'b1;
        if (bus.keystroke && (bus.keycode == (CTRL_CODE | 8'h80)))
            ctrl_down_d = 1'b0;
        if (brk_press)
            brk_down_d = 1'b1;
        if (brk_release)
            brk_down_d = 1'b0;
        if (rstwarn) begin
            ctrl_down_d = 1'b0;
            brk_down_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 16'd0;
            freeze_q    <= 1'b0;
            kbd_block_q <= 1'b0;
            ctrl_down_q <= 1'b0;
            brk_down_q  <= 1'b0;
            osd_del_q   <= 1'b0;
        end else begin
            ctrl_down_q <= ctrl_down_d;
            brk_down_q  <= brk_down_d;
            osd_del_q   <= bus.osd_freeze;
            kbd_block_q <= brk_match && (ctrl_down_q || brk_down_q);
            if (rstwarn) begin
                state_q  <= ST_GAP;
                cnt_q    <= GAP_RLD;
                freeze_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (trigger) begin
                            state_q  <= ST_PULSE;
                            cnt_q    <= PULSE_RLD;
                            freeze_q <= 1'b1;
                        end
                    end
                    ST_PULSE: begin
                        if (cnt_q == 16'd0) begin
                            state_q  <= ST_HOLD;
                            freeze_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q - 16'd1;
                        end
                    end
                    ST_HOLD: begin
                        // Leave as soon as the release strobe lands, not a cycle later.
                        if (!brk_down_d && !bus.osd_freeze) begin
                            state_q <= ST_GAP;
                            cnt_q   <= GAP_RLD;
                        end
                    end
                    ST_GAP: begin
                        if (brk_press || osd_rise)
                            cnt_q <= GAP_RLD;
                        else if (cnt_q == 16'd0)
                            state_q <= ST_IDLE;
                        else
                            cnt_q <= cnt_q - 16'd1;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.freeze    = freeze_q;
    assign bus.kbd_block = kbd_block_q;
    assign bus.ctrl_down = ctrl_down_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.state     = state_q;
endmodule

// File: tb/tb_ar_freeze_ctrl.sv
// Bench for ar_freeze_ctrl: directed scenarios plus random keystrokes, checked
// every cycle against a remaining-cycles model of the freeze/hold/gap rules.
module tb_ar_freeze_ctrl;
    localparam int PULSE_LEN = 16;
    localparam int GAP_LEN   = 1024;

    logic clk;
    logic _reset;
    ar_freeze_ctrl_if ifc ();

    ar_freeze_ctrl dut (
        .clk    (clk),
        ._reset (_reset),
        .bus    (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int frz_cycles = 0;

    // Model: cycles of freeze left, holding flag, cycles of gap left.
    bit m_ctrl, m_brk, m_osd_prev, m_block, m_holding;
    int m_freeze_left, m_gap_left;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ctrl = 0; m_brk = 0; m_osd_prev = 0; m_block = 0; m_holding = 0;
        m_freeze_left = 0; m_gap_left = 0;
    endtask

    task automatic model_step();
        logic [7:0] kc;
        bit ks, match, press, rise, trig, nctrl, nbrk;
        kc    = ifc.keycode;
        ks    = ifc.keystroke;
        match = ks && (kc[6:0] == 7'h5D);
        press = match && !kc[7];
        rise  = ifc.osd_freeze && !m_osd_prev;
        trig  = ifc.enable && ((ks && kc == 8'h5D && m_ctrl) || rise);
        nctrl = m_ctrl;
        nbrk  = m_brk;
        m_block = match && (m_ctrl || m_brk);
        if (ks && kc == 8'h63) nctrl = 1;
        if (ks && kc == 8'hE3) nctrl = 0;
        if (press) nbrk = 1;
        if (match && kc[7]) nbrk = 0;
        if (ks && kc == 8'h78) begin
            nctrl = 0; nbrk = 0;
            m_freeze_left = 0; m_holding = 0; m_gap_left = GAP_LEN;
        end else if (m_freeze_left > 0) begin
            m_freeze_left--;
            if (m_freeze_left == 0) m_holding = 1;
        end else if (m_holding) begin
            if (!nbrk && !ifc.osd_freeze) begin
                m_holding = 0; m_gap_left = GAP_LEN;
            end
        end else if (m_gap_left > 0) begin
            if (press || rise) m_gap_left = GAP_LEN;
            else m_gap_left--;
        end else if (trig) begin
            m_freeze_left = PULSE_LEN;
        end
        m_ctrl = nctrl;
        m_brk  = nbrk;
        m_osd_prev = ifc.osd_freeze;
    endtask

    task automatic compare_outputs();
        bit exp_busy;
        exp_busy = (m_freeze_left > 0) || m_holding || (m_gap_left > 0);
        check("freeze",    int'(ifc.freeze),    int'(m_freeze_left > 0));
        check("kbd_block", int'(ifc.kbd_block), int'(m_block));
        check("ctrl_down", int'(ifc.ctrl_down), int'(m_ctrl));
        check("busy",      int'(ifc.busy),      int'(exp_busy));
        if (ifc.freeze) frz_cycles++;
    endtask

    // One clock: model advances on the edge, outputs compared on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic strobe(input logic [7:0] kc);
        ifc.keycode   = kc;
        ifc.keystroke = 1'b1;
        tick();
        ifc.keystroke = 1'b0;
        ifc.keycode   = 8'h00;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (ifc.busy && n < 3000);
    endtask

    int n;
    int base;
    int guard;
    int pick;
    logic [7:0] kc;

    initial begin
        ifc.keycode = 8'h00; ifc.keystroke = 1'b0; ifc.osd_freeze = 1'b0; ifc.enable = 1'b1;
        _reset = 1'b1;
        model_reset();
        #2 _reset = 1'b0;
        #1;
        check("rst_freeze", int'(ifc.freeze), 0);
        check("rst_busy",   int'(ifc.busy), 0);
        check("rst_ctrl",   int'(ifc.ctrl_down), 0);
        check("rst_block",  int'(ifc.kbd_block), 0);
        check("rst_state",  int'(ifc.state), 0);
        @(posedge clk);
        #2 _reset = 1'b1;
        @(negedge clk);

        // Ctrl+Break, repeated Break, release: one 16-cycle pulse.
        base = frz_cycles;
        strobe(8'h63);
        strobe(8'h5D);
        check("t1_block", int'(ifc.kbd_block), 1);
        check("t1_freeze_lat", int'(ifc.freeze), 1);
        check("t1_busy", int'(ifc.busy), 1);
        repeat (4) tick();
        strobe(8'h5D);
        check("t1_block2", int'(ifc.kbd_block), 1);
        repeat (100) tick();
        strobe(8'hDD);
        check("t1_block3", int'(ifc.kbd_block), 1);
        wait_idle(n);
        check("t1_idle_after_release", n, 1024);
        check("t1_pulse_len", frz_cycles - base, 16);
        strobe(8'hE3);
        check("t1_ctrl_up", int'(ifc.ctrl_down), 0);

        // Break alone: nothing happens.
        base = frz_cycles;
        strobe(8'h5D);
        check("t2_block", int'(ifc.kbd_block), 0);
        repeat (20) tick();
        check("t2_no_freeze", frz_cycles - base, 0);
        check("t2_busy", int'(ifc.busy), 0);
        strobe(8'hDD);
        check("t2_rel_block", int'(ifc.kbd_block), 1);

        // Gap reload by a Break press at cnt==10.
        strobe(8'h63);
        strobe(8'h5D);
        strobe(8'hE3);
        strobe(8'hDD);
        guard = 0;
        while (m_gap_left != 11 && guard < 3000) begin tick(); guard++; end
        check("t3_reach_gap", m_gap_left, 11);
        base = frz_cycles;
        strobe(8'h5D);
        check("t3_block_noctrl", int'(ifc.kbd_block), 0);
        strobe(8'hDD);
        check("t3_rel_block", int'(ifc.kbd_block), 1);
        wait_idle(n);
        check("t3_gap_restart", n, 1023);
        check("t3_no_freeze", frz_cycles - base, 0);
        strobe(8'h63);
        strobe(8'h5D);
        check("t3_new_pulse", int'(ifc.freeze), 1);
        strobe(8'hE3);
        strobe(8'hDD);
        wait_idle(n);
        check("t3_pulse_hold_gap", n, 1039);

        // OSD request: edge triggers, level holds, fall starts the gap.
        ifc.osd_freeze = 1'b1;
        tick();
        check("t4_osd_freeze", int'(ifc.freeze), 1);
        repeat (5000) tick();
        check("t4_hold_busy", int'(ifc.busy), 1);
        check("t4_hold_freeze", int'(ifc.freeze), 0);
        ifc.osd_freeze = 1'b0;
        wait_idle(n);
        check("t4_gap_after_fall", n, 1025);
        ifc.enable = 1'b0;
        ifc.osd_freeze = 1'b1;
        repeat (10) tick();
        check("t4_disabled", int'(ifc.busy), 0);
        ifc.osd_freeze = 1'b0;
        ifc.enable = 1'b1;
        tick();

        // Reset-warning mid-pulse aborts it.
        strobe(8'h63);
        strobe(8'h5D);
        guard = 0;
        while (m_freeze_left != 8 && guard < 50) begin tick(); guard++; end
        strobe(8'h78);
        check("t5_abort_freeze", int'(ifc.freeze), 0);
        check("t5_ctrl_clear", int'(ifc.ctrl_down), 0);
        check("t5_busy", int'(ifc.busy), 1);
        wait_idle(n);
        check("t5_gap", n, 1024);

        // Random keystrokes and OSD activity.
        for (int i = 0; i < 3000; i++) begin
            ifc.enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 199) == 0) ifc.osd_freeze = ~ifc.osd_freeze;
            if ($urandom_range(0, 7) == 0) begin
                pick = $urandom_range(0, 7);
                case (pick)
                    0: kc = 8'h63;
                    1: kc = 8'hE3;
                    2: kc = 8'h5D;
                    3: kc = 8'hDD;
                    4: kc = ($urandom_range(0, 3) == 0) ? 8'h78 : 8'h5D;
                    default: kc = 8'($urandom_range(0, 255));
                endcase
                strobe(kc);
            end else begin
                tick();
            end
        end

        // Asynchronous reset during a pulse.
        ifc.osd_freeze = 1'b0;
        ifc.enable = 1'b1;
        strobe(8'h78);
        wait_idle(n);
        strobe(8'h63);
        strobe(8'h5D);
        check("t7_pulse", int'(ifc.freeze), 1);
        repeat (3) tick();
        #2 _reset = 1'b0;
        #1;
        check("t7_async_freeze", int'(ifc.freeze), 0);
        check("t7_async_busy", int'(ifc.busy), 0);
        check("t7_async_ctrl", int'(ifc.ctrl_down), 0);
        model_reset();
        @(posedge clk);
        #2 _reset = 1'b1;
        repeat (5) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
